// File: rtl/bram_s16_pkg.sv
// Shared constants and state encoding for the 256x16 block RAM
// arbiter slice.
package bram_s16_pkg;

    localparam int RAM_DEPTH = 256;
    localparam int RAM_AW    = 8;
    localparam int RAM_DW    = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: a single requester always wins; on a tie the
// winner is either fixed (port 0) or the port that did not win last.
module rr_arb2 #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = valid[0] | valid[1];
        gnt_idx = 1'b0;
        unique case (1'b1)
            valid[0] && valid[1]:
                gnt_idx = FIXED_PRIORITY ? 1'b0 : ~last_grant;
            valid[1] && !valid[0]:
                gnt_idx = 1'b1;
            default:
                gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bram_s16_arbiter.sv
// Two-requester sequencer for a single-port 256x16 block RAM with
// optional post-reset clear and per-port response steering.
module bram_s16_arbiter
    import bram_s16_pkg::*;
#(
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [RAM_DW-1:0] CLEAR_VALUE    = 16'h0000,
    parameter bit                FIXED_PRIORITY = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic              REQ0_WE,
    input  logic [RAM_AW-1:0] REQ0_ADDR,
    input  logic [RAM_DW-1:0] REQ0_DI,
    output logic              RSP0_VALID,
    output logic [RAM_DW-1:0] RSP0_DO,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic              REQ1_WE,
    input  logic [RAM_AW-1:0] REQ1_ADDR,
    input  logic [RAM_DW-1:0] REQ1_DI,
    output logic              RSP1_VALID,
    output logic [RAM_DW-1:0] RSP1_DO,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic [RAM_DW-1:0] RAM_DI,
    input  logic [RAM_DW-1:0] RAM_DO,
    output logic              BUSY
);

    localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(RAM_DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [RAM_AW-1:0] clr_cnt;
    logic              last_grant;
    logic              rsp_valid;
    logic              rsp_sel;
    logic              gnt_idx;
    logic              gnt_vld;
    logic              accept;

    rr_arb2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .valid      ({REQ1_VALID, REQ0_VALID}),
        .last_grant (last_grant),
        .gnt_idx    (gnt_idx),
        .gnt_vld    (gnt_vld)
    );

    // A grant only exists when its VALID is high, so grant == accept.
    assign accept = (state == ST_RUN) && gnt_vld;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt    <= '0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_sel    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= accept;
            if (state == ST_CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            if (accept) begin
                last_grant <= gnt_idx;
                rsp_sel    <= gnt_idx;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        RAM_EN     = 1'b0;
        RAM_WE     = 1'b0;
        RAM_ADDR   = '0;
        RAM_DI     = '0;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        BUSY       = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                RAM_EN   = 1'b1;
                RAM_WE   = 1'b1;
                RAM_ADDR = clr_cnt;
                RAM_DI   = CLEAR_VALUE;
                BUSY     = 1'b1;
                if (clr_cnt == LAST_ADDR)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                REQ0_READY = gnt_vld && !gnt_idx;
                REQ1_READY = gnt_vld && gnt_idx;
                if (gnt_vld) begin
                    RAM_EN   = 1'b1;
                    RAM_WE   = gnt_idx ? REQ1_WE : REQ0_WE;
                    RAM_ADDR = gnt_idx ? REQ1_ADDR : REQ0_ADDR;
                    RAM_DI   = gnt_idx ? REQ1_DI : REQ0_DI;
                end
            end
        endcase
    end

    assign RSP0_VALID = rsp_valid && !rsp_sel;
    assign RSP1_VALID = rsp_valid && rsp_sel;
    assign RSP0_DO    = !rsp_sel ? RAM_DO : '0;
    assign RSP1_DO    = rsp_sel ? RAM_DO : '0;

endmodule

// File: tb/tb_bram_s16_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter, each
// with its own behavioural RAM, against an abstract memory model.
module tb_bram_s16_arbiter;

    typedef struct packed {
        logic        p;
        logic [15:0] d;
    } rsp_t;

    logic        CLK;
    logic        RST;
    logic        rv   [2][2];
    logic        rwe  [2][2];
    logic [7:0]  ra   [2][2];
    logic [15:0] rd   [2][2];
    logic        rdy  [2][2];
    logic        sv   [2][2];
    logic [15:0] sdo  [2][2];
    logic        ren  [2];
    logic        rwo  [2];
    logic [7:0]  raddr[2];
    logic [15:0] rdi  [2];
    logic [15:0] rdo  [2];
    logic        busy [2];

    int          total = 0;
    int          bad = 0;
    rsp_t        q0[$];
    rsp_t        q1[$];
    logic [15:0] mm[2][256];
    bit          lastg[2];
    bit          acc[2][2];
    int          busy_left = 256;
    bit          warm = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [256];
        bit          seeded = 1'b0;

        bram_s16_arbiter #(
            .CLEAR_ON_RESET (1'b1),
            .CLEAR_VALUE    (16'h0000),
            .FIXED_PRIORITY (g == 1)
        ) u_dut (
            .CLK        (CLK),
            .RST        (RST),
            .REQ0_VALID (rv[g][0]),
            .REQ0_READY (rdy[g][0]),
            .REQ0_WE    (rwe[g][0]),
            .REQ0_ADDR  (ra[g][0]),
            .REQ0_DI    (rd[g][0]),
            .RSP0_VALID (sv[g][0]),
            .RSP0_DO    (sdo[g][0]),
            .REQ1_VALID (rv[g][1]),
            .REQ1_READY (rdy[g][1]),
            .REQ1_WE    (rwe[g][1]),
            .REQ1_ADDR  (ra[g][1]),
            .REQ1_DI    (rd[g][1]),
            .RSP1_VALID (sv[g][1]),
            .RSP1_DO    (sdo[g][1]),
            .RAM_EN     (ren[g]),
            .RAM_WE     (rwo[g]),
            .RAM_ADDR   (raddr[g]),
            .RAM_DI     (rdi[g]),
            .RAM_DO     (rdo[g]),
            .BUSY       (busy[g])
        );

        // Single-port RAM, write-through, garbage contents at power-up.
        always @(posedge CLK) begin
            if (!seeded) begin
                for (int k = 0; k < 256; k++)
                    mem[k] <= 16'($urandom);
                seeded <= 1'b1;
            end else if (ren[g]) begin
                if (rwo[g]) begin
                    mem[raddr[g]] <= rdi[g];
                    rdo[g]        <= rdi[g];
                end else begin
                    rdo[g] <= mem[raddr[g]];
                end
            end
        end
    end

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%h want=%h", nm, i, act, exp);
        end
    endtask

    // Monitor: pop the oldest expected response whenever one appears.
    rsp_t        me;
    logic        mgp;
    logic [15:0] mgd;
    int          mqs;
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (sv[i][0] || sv[i][1]) begin
                mgp = sv[i][1];
                mgd = mgp ? sdo[i][1] : sdo[i][0];
                chk("rsp_onehot", i, 32'(sv[i][0] & sv[i][1]), 32'd0);
                mqs = (i == 0) ? q0.size() : q1.size();
                if (mqs == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected inst%0d got=%h want=none",
                             i, mgd);
                end else begin
                    if (i == 0) me = q0.pop_front();
                    else        me = q1.pop_front();
                    chk("rsp_port", i, 32'(mgp), 32'(me.p));
                    chk("rsp_data", i, 32'(mgd), 32'(me.d));
                    chk("rsp_other_do", i,
                        32'(mgp ? sdo[i][0] : sdo[i][1]), 32'd0);
                end
            end
        end
    end

    // One clock of model evaluation; inputs are already applied.
    task automatic cycle(input bit rst);
        bit          gv;
        bit          g;
        logic [15:0] d;
        rsp_t        e;
        RST = rst;
        #1;
        for (int i = 0; i < 2; i++) begin
            acc[i][0] = 1'b0;
            acc[i][1] = 1'b0;
            if (warm) begin
                chk("busy", i, 32'(busy[i]), 32'(busy_left > 0));
                if (busy_left > 0) begin
                    chk("ready_busy", i,
                        32'({rdy[i][0], rdy[i][1]}), 32'd0);
                    if (!rst)
                        chk("clear_wr", i,
                            32'({ren[i], rwo[i], raddr[i], rdi[i]}),
                            32'({2'b11, 8'(256 - busy_left), 16'h0000}));
                end else begin
                    gv = rv[i][0] || rv[i][1];
                    if (rv[i][0] && rv[i][1])
                        g = (i == 1) ? 1'b0 : !lastg[i];
                    else
                        g = rv[i][1];
                    chk("ready", i, 32'({rdy[i][0], rdy[i][1]}),
                        32'({gv && !g, gv && g}));
                    if (gv) begin
                        chk("ram_cmd", i,
                            32'({ren[i], rwo[i], raddr[i], rdi[i]}),
                            32'({1'b1, rwe[i][g], ra[i][g], rd[i][g]}));
                        d = rwe[i][g] ? rd[i][g] : mm[i][ra[i][g]];
                        if (rwe[i][g])
                            mm[i][ra[i][g]] = rd[i][g];
                        if (!rst) begin
                            e.p = g;
                            e.d = d;
                            if (i == 0) q0.push_back(e);
                            else        q1.push_back(e);
                        end
                        lastg[i]  = g;
                        acc[i][g] = 1'b1;
                    end else begin
                        chk("ram_idle", i, 32'({ren[i], rwo[i]}), 32'd0);
                    end
                end
            end
        end
        if (rst) begin
            busy_left = 256;
            lastg     = '{1'b1, 1'b1};
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 256; k++)
                    mm[i][k] = 16'h0000;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input int p, input bit v, input bit we,
                       input logic [7:0] a, input logic [15:0] d);
        for (int i = 0; i < 2; i++) begin
            rv[i][p]  = v;
            rwe[i][p] = we;
            ra[i][p]  = a;
            rd[i][p]  = d;
        end
    endtask

    task automatic regen();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                if (!rv[i][p] || acc[i][p]) begin
                    rv[i][p]  = ($urandom_range(0, 3) != 0);
                    rwe[i][p] = 1'($urandom_range(0, 1));
                    ra[i][p]  = 8'($urandom_range(0, 15));
                    rd[i][p]  = 16'($urandom);
                end
    endtask

    task automatic run_clear(output int n);
        n = 0;
        while (busy[0] && n < 600) begin
            cycle(1'b0);
            n++;
        end
    endtask

    int n;

    initial begin
        RST = 1'b1;
        req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        cycle(1'b1);
        warm = 1'b1;
        // Port 0 read held through the whole clear.
        req(0, 1'b1, 1'b0, 8'h37, 16'h0000);
        cycle(1'b1);
        run_clear(n);
        chk("clear_len", 0, 32'(n), 32'd256);
        cycle(1'b0);
        req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cycle(1'b0);

        req(0, 1'b1, 1'b1, 8'h12, 16'hBEEF);
        cycle(1'b0);
        req(0, 1'b1, 1'b0, 8'h12, 16'h0000);
        cycle(1'b0);
        req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) cycle(1'b0);

        req(0, 1'b1, 1'b1, 8'h01, 16'hA1A1);
        cycle(1'b0);
        req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        req(1, 1'b1, 1'b1, 8'h02, 16'hB2B2);
        cycle(1'b0);
        req(0, 1'b1, 1'b0, 8'h01, 16'h0000);
        req(1, 1'b1, 1'b0, 8'h02, 16'h0000);
        repeat (8) cycle(1'b0);
        req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) cycle(1'b0);
        req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        cycle(1'b0);

        req(0, 1'b1, 1'b1, 8'h40, 16'h1234);
        cycle(1'b0);
        req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        req(1, 1'b1, 1'b0, 8'h40, 16'h0000);
        cycle(1'b0);
        req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) cycle(1'b0);

        for (int c = 0; c < 1500; c++) begin
            cycle(1'b0);
            regen();
        end
        req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) cycle(1'b0);

        // Reset at clear count 100 restarts the sweep.
        cycle(1'b1);
        repeat (100) cycle(1'b0);
        cycle(1'b1);
        run_clear(n);
        chk("clear_restart_len", 0, 32'(n), 32'd256);

        // Reset in the cycle of an accept drops its response.
        req(0, 1'b1, 1'b1, 8'h55, 16'hDEAD);
        cycle(1'b1);
        req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 2; i++)
            chk("rsp_dropped", i, 32'({sv[i][0], sv[i][1]}), 32'd0);
        run_clear(n);
        chk("clear_len_2", 0, 32'(n), 32'd256);
        req(1, 1'b1, 1'b0, 8'h55, 16'h0000);
        cycle(1'b0);
        req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) cycle(1'b0);

        chk("q0_drained", 0, 32'(q0.size()), 32'd0);
        chk("q1_drained", 1, 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
